// File: rtl/muldiv_unit.sv
// Multi-cycle MUL/DIV beside the execute ALU: MUL in MUL_LAT+1 cycles, DIV in XLEN+1 (word: 33), corner DIV/REM in 1.
// Stalls execute through e_wait_o until the result is in c_o; the result is held until ack_i, and flush_i kills the op.
module muldiv_unit #(
   parameter int MUL_LAT = 3,
   parameter int XLEN    = 64
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            req_i,
   input  logic [1:0]      op_i,
   input  logic            sign_i,
   input  logic            cut_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic            ack_i,
   input  logic            flush_i,
   output logic [XLEN-1:0] c_o,
   output logic            e_wait_o,
   output logic            busy_o
);
   localparam int CMAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [1:0] OP_MUL  = 2'b00;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_MULH = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] c_q, c_d, a_q, a_d, b_q, b_d;
   logic [XLEN-1:0] dvs_q, dvs_d, quo_q, quo_d, rem_q, rem_d;
   logic [1:0]      op_q, op_d;
   logic            sign_q, sign_d, cut_q, cut_d;
   logic            a_neg_q, a_neg_d, q_neg_q, q_neg_d;

   function automatic logic [XLEN-1:0] word_ext(input logic [XLEN-1:0] v, input logic w);
      return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
   endfunction

   // Operand conditioning straight from the execute-stage inputs
   logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, min_val, quo_init;
   logic            a_neg, b_neg, div_zero, div_ovf;

   always_comb begin
      a_ext = a_i;
      b_ext = b_i;
      if (cut_i) begin
         a_ext = {{(XLEN-32){sign_i & a_i[31]}}, a_i[31:0]};
         b_ext = {{(XLEN-32){sign_i & b_i[31]}}, b_i[31:0]};
      end
      min_val  = cut_i ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
      a_neg    = sign_i & a_ext[XLEN-1];
      b_neg    = sign_i & b_ext[XLEN-1];
      a_abs    = a_neg ? -a_ext : a_ext;
      b_abs    = b_neg ? -b_ext : b_ext;
      // Word divides run 32 iterations, so the dividend starts MSB-aligned
      quo_init = cut_i ? {a_abs[31:0], {(XLEN-32){1'b0}}} : a_abs;
      div_zero = (b_ext == '0);
      div_ovf  = sign_i && (a_ext == min_val) && (b_ext == '1);
   end

   // One restoring step; rem_q < divisor keeps rem_sh's MSB clear, so diff's MSB is the borrow
   logic [XLEN:0]   rem_sh, diff;
   logic [XLEN-1:0] quo_nx, rem_nx, q_fix, r_fix, div_res;

   always_comb begin
      rem_sh  = {rem_q, quo_q[XLEN-1]};
      diff    = rem_sh - {1'b0, dvs_q};
      quo_nx  = {quo_q[XLEN-2:0], ~diff[XLEN]};
      rem_nx  = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
      q_fix   = q_neg_q ? -quo_nx : quo_nx;
      r_fix   = a_neg_q ? -rem_nx : rem_nx;
      div_res = word_ext((op_q == OP_REM) ? r_fix : q_fix, cut_q);
   end

   logic [2*XLEN-1:0] a_wide, b_wide, prod;
   logic [XLEN-1:0]   mul_res;

   always_comb begin
      a_wide  = {{XLEN{sign_q & a_q[XLEN-1]}}, a_q};
      b_wide  = {{XLEN{sign_q & b_q[XLEN-1]}}, b_q};
      prod    = a_wide * b_wide;
      mul_res = (op_q == OP_MULH && !cut_q) ? prod[2*XLEN-1:XLEN]
                                            : word_ext(prod[XLEN-1:0], cut_q);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      c_d     = c_q;
      a_d     = a_q;
      b_d     = b_q;
      dvs_d   = dvs_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      op_d    = op_q;
      sign_d  = sign_q;
      cut_d   = cut_q;
      a_neg_d = a_neg_q;
      q_neg_d = q_neg_q;
      case (state_q)
         S_IDLE: begin
            if (req_i) begin
               a_d     = a_ext;
               b_d     = b_ext;
               dvs_d   = b_abs;
               quo_d   = quo_init;
               rem_d   = '0;
               op_d    = op_i;
               sign_d  = sign_i;
               cut_d   = cut_i;
               a_neg_d = a_neg;
               q_neg_d = a_neg ^ b_neg;
               if (op_i == OP_MUL || op_i == OP_MULH) begin
                  state_d = S_MUL;
                  cnt_d   = CW'(MUL_LAT);
               end else if (div_zero) begin
                  state_d = S_DONE;
                  c_d     = word_ext((op_i == OP_REM) ? a_ext : '1, cut_i);
               end else if (div_ovf) begin
                  state_d = S_DONE;
                  c_d     = word_ext((op_i == OP_REM) ? '0 : a_ext, cut_i);
               end else begin
                  state_d = S_DIV;
                  cnt_d   = cut_i ? CW'(32) : CW'(XLEN);
               end
            end
         end
         S_MUL: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               c_d     = mul_res;
               state_d = S_DONE;
            end
         end
         S_DIV: begin
            cnt_d = cnt_q - CW'(1);
            quo_d = quo_nx;
            rem_d = rem_nx;
            if (cnt_q == CW'(1)) begin
               c_d     = div_res;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (ack_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // A redirect beats ack and req and leaves the last result untouched
      if (flush_i) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         c_d     = c_q;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         c_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         dvs_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         op_q    <= '0;
         sign_q  <= 1'b0;
         cut_q   <= 1'b0;
         a_neg_q <= 1'b0;
         q_neg_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         a_q     <= a_d;
         b_q     <= b_d;
         dvs_q   <= dvs_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         op_q    <= op_d;
         sign_q  <= sign_d;
         cut_q   <= cut_d;
         a_neg_q <= a_neg_d;
         q_neg_q <= q_neg_d;
      end
   end

   assign c_o      = c_q;
   assign busy_o   = (state_q != S_IDLE);
   assign e_wait_o = req_i && (state_q != S_DONE) && !reset_i;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results and stall lengths are queued at issue and checked at DONE.
module tb_muldiv_unit;
   logic        clk = 1'b0;
   logic        reset, req, sign, cut, ack, flush;
   logic [1:0]  op;
   logic [63:0] a, b, c;
   logic        e_wait, busy;

   int          tests = 0;
   int          fails = 0;
   logic [63:0] exp_q[$];
   int          wait_q[$];
   logic [63:0] last_c = 64'd0;

   always #5 clk = ~clk;

   muldiv_unit #(.MUL_LAT(3), .XLEN(64)) dut (
      .clk_i(clk), .reset_i(reset), .req_i(req), .op_i(op), .sign_i(sign), .cut_i(cut),
      .a_i(a), .b_i(b), .ack_i(ack), .flush_i(flush),
      .c_o(c), .e_wait_o(e_wait), .busy_o(busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ext(input logic [63:0] v, input logic s, input logic ct);
      if (!ct) return v;
      return s ? {{32{v[31]}}, v[31:0]} : {32'h0, v[31:0]};
   endfunction

   function automatic logic [63:0] model(input logic [1:0] o, input logic s, input logic ct,
                                         input logic [63:0] x0, input logic [63:0] y0);
      logic [63:0]        x, y, q, r, res;
      logic signed [63:0] xs, ys;
      logic signed [127:0] xw, yw, p;
      x = ext(x0, s, ct);
      y = ext(y0, s, ct);
      if (o == 2'b00 || o == 2'b11) begin
         xw  = s ? $signed({{64{x[63]}}, x}) : $signed({64'h0, x});
         yw  = s ? $signed({{64{y[63]}}, y}) : $signed({64'h0, y});
         p   = xw * yw;
         res = (o == 2'b11 && !ct) ? p[127:64] : p[63:0];
      end else begin
         xs = x;
         ys = y;
         if (y == 64'd0) begin
            q = '1; r = x;
         end else if (s && x == 64'h8000_0000_0000_0000 && y == '1) begin
            q = x; r = 64'd0;
         end else if (s) begin
            q = xs / ys; r = xs % ys;
         end else begin
            q = x / y; r = x % y;
         end
         res = (o == 2'b10) ? r : q;
      end
      return ct ? {{32{res[31]}}, res[31:0]} : res;
   endfunction

   function automatic int model_waits(input logic [1:0] o, input logic s, input logic ct,
                                      input logic [63:0] x0, input logic [63:0] y0);
      logic [63:0] x, y;
      x = ext(x0, s, ct);
      y = ext(y0, s, ct);
      if (o == 2'b00 || o == 2'b11) return 4;
      if (y == 64'd0) return 1;
      if (s && y == '1 && x == (ct ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) return 1;
      return ct ? 33 : 65;
   endfunction

   // Called just after a rising edge; returns at the falling edge of the first DONE cycle.
   task automatic do_op(input string tag, input logic [1:0] o, input logic s, input logic ct,
                        input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] exp, input int waits);
      int n;
      req = 1'b1; op = o; sign = s; cut = ct; a = x; b = y;
      exp_q.push_back(exp);
      wait_q.push_back(waits);
      n = 0;
      @(negedge clk);
      while (e_wait === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
      check({tag, ".wait"}, 64'(n), 64'(wait_q.pop_front()));
      last_c = exp_q.pop_front();
      check({tag, ".c"}, c, last_c);
   endtask

   task automatic finish_op(input string tag);
      @(posedge clk); #1 ack = 1'b1; req = 1'b0;
      @(posedge clk); #1 ack = 1'b0;
      check({tag, ".idle"}, 64'(busy), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [1:0]  ro;
      logic        rs, rc;
      logic [63:0] rx, ry;

      reset = 1'b1; req = 1'b0; op = 2'b00; sign = 1'b0; cut = 1'b0;
      a = 64'd0; b = 64'd0; ack = 1'b0; flush = 1'b0;
      #12;
      check("rst.c", c, 64'd0);
      check("rst.ewait", 64'(e_wait), 64'd0);
      check("rst.busy", 64'(busy), 64'd0);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;

      do_op("mul", 2'b00, 1, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 4);
      finish_op("mul");
      do_op("div", 2'b01, 1, 0, 64'd100, 64'd7, 64'd14, 65);
      finish_op("div");
      do_op("rem", 2'b10, 1, 0, 64'd100, 64'd7, 64'd2, 65);
      finish_op("rem");
      do_op("remneg", 2'b10, 1, 0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65);
      finish_op("remneg");
      do_op("div0", 2'b01, 1, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      finish_op("div0");
      do_op("rem0", 2'b10, 1, 0, 64'd5, 64'd0, 64'd5, 1);
      finish_op("rem0");
      do_op("ovf", 2'b01, 1, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0000, 1);
      finish_op("ovf");
      do_op("divuw", 2'b01, 0, 1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
      finish_op("divuw");
      do_op("divw", 2'b01, 1, 1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002,
            64'hFFFF_FFFF_FFFF_FFFD, 33);
      finish_op("divw");
      do_op("remwovf", 2'b10, 1, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 1);
      finish_op("remwovf");
      do_op("mulw", 2'b00, 1, 1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 4);
      finish_op("mulw");
      do_op("mulhu", 2'b11, 0, 0, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 4);
      finish_op("mulhu");
      do_op("mulh", 2'b11, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 4);
      finish_op("mulh");

      // Result held in DONE with req still asserted and no ack
      do_op("hold", 2'b00, 0, 0, 64'd6, 64'd7, 64'd42, 4);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold.c", c, 64'd42);
         check("hold.ewait", 64'(e_wait), 64'd0);
      end
      finish_op("hold");
      do_op("b2b", 2'b00, 0, 0, 64'h0000_0001_0000_0000, 64'd3, 64'h0000_0003_0000_0000, 4);
      finish_op("b2b");

      // ack during DIV is ignored, then flush in DIV cycle 10
      req = 1'b1; op = 2'b01; sign = 1'b0; cut = 1'b0; a = 64'd1000; b = 64'd3;
      repeat (5) @(posedge clk);
      #1 ack = 1'b1;
      @(posedge clk); #1 ack = 1'b0;
      check("ackign.busy", 64'(busy), 64'd1);
      check("ackign.ewait", 64'(e_wait), 64'd1);
      repeat (4) @(posedge clk);
      #1 flush = 1'b1; req = 1'b0;
      @(posedge clk); #1 flush = 1'b0;
      check("flush.busy", 64'(busy), 64'd0);
      check("flush.ewait", 64'(e_wait), 64'd0);
      check("flush.c", c, last_c);

      // flush beats a request in IDLE
      req = 1'b1; op = 2'b00; a = 64'd11; b = 64'd13; flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0; req = 1'b0;
      check("flushreq.busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      check("flushreq.c", c, last_c);

      for (int i = 0; i < 12; i++) begin
         ro = 2'($urandom_range(0, 3));
         rs = 1'($urandom_range(0, 1));
         rc = 1'($urandom_range(0, 1));
         rx = {$urandom, $urandom};
         ry = {$urandom, $urandom};
         if (i % 3 == 0) ry = 64'($urandom_range(0, 9));
         if (i % 4 == 1) rx = 64'($urandom_range(0, 1000));
         if (i % 5 == 2) ry = {32'h0, 32'hFFFF_FFFF} | {32'($urandom), 32'h0};
         do_op("rnd", ro, rs, rc, rx, ry, model(ro, rs, rc, rx, ry), model_waits(ro, rs, rc, rx, ry));
         finish_op("rnd");
      end

      // Async reset in the middle of a multiply
      req = 1'b1; op = 2'b00; sign = 1'b0; cut = 1'b0; a = 64'd3; b = 64'd5;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1; req = 1'b0;
      #1;
      check("midrst.c", c, 64'd0);
      check("midrst.ewait", 64'(e_wait), 64'd0);
      check("midrst.busy", 64'(busy), 64'd0);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      do_op("postrst", 2'b00, 0, 0, 64'd5, 64'd5, 64'd25, 4);
      finish_op("postrst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
